// File: rtl/ppc_types.sv
// ppc_types: shared PowerPC pipeline types (condition/exception flags, CDB payload)
package ppc_types;
  localparam int RS_ID_WIDTH = 5;
  typedef struct packed {
    logic [3:0] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
    logic [31:0]            result;
    cond_exception_t        cr0_xer;
  } cdb_t;
endpackage

// File: rtl/result_bus_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant over req; round-robin when RESULT_BUS_ROUND_ROBIN_EN is defined, else fixed lowest-index priority
//   clk, rst (async active-low), req[PORTS], advance (a granted request is actually taken), grant[PORTS] one-hot
module rr_arbiter #(
  parameter int PORTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  input  logic             advance,
  output logic [PORTS-1:0] grant
);
`ifdef RESULT_BUS_ROUND_ROBIN_EN
  localparam int PW = $clog2(PORTS);
  logic [PW-1:0] ptr, gidx;
  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int idx;
    idx = 0;
    grant = '0;
    gidx = ptr;
    for (int k = PORTS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % PORTS;
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        gidx = PW'(idx);
      end
    end
  end
  // Pointer moves only when the grant turns into a transfer.
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= PW'(PORTS - 1);
    else if (advance && |grant) ptr <= gidx;
`else
  logic unused;
  assign unused = ^{clk, rst, advance};
  assign grant = req & (~req + PORTS'(1));
`endif
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: serialises execution-unit results onto the common data bus through one registered stage
//   clk, rst (async active-low); unit_valid/unit_ready/unit_rs_id/unit_reg_addr/unit_result/unit_cr0_xer: flat per-unit result ports;
//   cdb_valid/cdb_ready/cdb_rs_id/cdb_reg_addr/cdb_result/cdb_cr0_xer/cdb_port: broadcast output.
//   Define RESULT_BUS_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 highest).
module result_bus_arbiter
  import ppc_types::*;
#(
  parameter int PORTS       = 4,
  parameter int RS_ID_WIDTH = ppc_types::RS_ID_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           unit_valid,
  output logic [PORTS-1:0]           unit_ready,
  input  logic [PORTS*RS_ID_WIDTH-1:0] unit_rs_id,
  input  logic [PORTS*5-1:0]         unit_reg_addr,
  input  logic [PORTS*32-1:0]        unit_result,
  input  logic [PORTS*$bits(cond_exception_t)-1:0] unit_cr0_xer,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [RS_ID_WIDTH-1:0]     cdb_rs_id,
  output logic [4:0]                 cdb_reg_addr,
  output logic [31:0]                cdb_result,
  output cond_exception_t            cdb_cr0_xer,
  output logic [$clog2(PORTS)-1:0]   cdb_port
);
  localparam int PW = $clog2(PORTS);
  localparam int CW = $bits(cond_exception_t);
  logic [PORTS-1:0] grant;
  logic             free;
  logic [PW-1:0]    gidx;
  cdb_t             sel, cdb_q;
  assign free = !cdb_valid || cdb_ready;
  // Gated by rst so no unit sees an accept while the output register is held in reset.
  assign unit_ready = grant & {PORTS{free & rst}};
  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(unit_valid),
    .advance(free),
    .grant(grant)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < PORTS; i++) if (grant[i]) gidx = PW'(i);
    sel = '0;
    sel.rs_id = unit_rs_id[int'(gidx)*RS_ID_WIDTH +: RS_ID_WIDTH];
    sel.reg_addr = unit_reg_addr[int'(gidx)*5 +: 5];
    sel.result = unit_result[int'(gidx)*32 +: 32];
    sel.cr0_xer = unit_cr0_xer[int'(gidx)*CW +: CW];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_q <= '0;
      cdb_port <= '0;
    end else if (free) begin
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_q <= sel;
        cdb_port <= gidx;
      end
    end
  assign cdb_rs_id = cdb_q.rs_id;
  assign cdb_reg_addr = cdb_q.reg_addr;
  assign cdb_result = cdb_q.result;
  assign cdb_cr0_xer = cdb_q.cr0_xer;
endmodule
